bcd_seg_encoder: RTL and testbench

Converts a 14-bit binary count into four active-low seven-segment patterns for the four-digit display multiplexer stage. Sits directly upstream of the display multiplexer: its `seg0`–`seg3` outputs drive that block's `seg0`–`seg3` inputs, with `seg0` as the leftmost digit (thousands) and `seg3` as the rightmost (units). Conversion is iterative (shift-and-add-3, one bit per cycle) and uses a load/busy/done handshake. Outputs update atomically, so the multiplexer never shows a partially converted value.

---
 rtl/bcd_seg_encoder.sv | 148 ++++++++++++++
 tb/tb_bcd_seg_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_encoder.sv
// Binary-to-seven-segment converter: 14-bit count -> four active-low digit patterns.
// Iterative double-dabble conversion with load/busy/done handshake and atomic output update.
module bcd_seg_encoder #(
    parameter logic BLANK_LEADING = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [13:0] Value,
    input  logic        Load,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    state_t      state_q;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  seg0_q, seg1_q, seg2_q, seg3_q;

    logic [15:0] bcd_adj;
    logic [29:0] shift_d;
    logic [7:0]  seg0_d, seg1_d, seg2_d, seg3_d;
    logic        blank0, blank1, blank2;

    function automatic logic [15:0] add3_all(input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  nib;
        r = b;
        for (int i = 0; i < 4; i++) begin
            nib = b[i*4 +: 4];
            if (nib >= 4'd5) begin
                r[i*4 +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

    // Non-decimal nibbles fall through to blank.
    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign bcd_adj = add3_all(bcd_q);
    assign shift_d = {bcd_adj, bin_q} << 1;

    always_comb begin
        blank0 = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
        blank1 = blank0 && (bcd_q[11:8] == 4'd0);
        blank2 = blank1 && (bcd_q[7:4] == 4'd0);
        seg0_d = blank0 ? SEG_BLANK : digit_seg(bcd_q[15:12]);
        seg1_d = blank1 ? SEG_BLANK : digit_seg(bcd_q[11:8]);
        seg2_d = blank2 ? SEG_BLANK : digit_seg(bcd_q[7:4]);
        seg3_d = digit_seg(bcd_q[3:0]);
        if (ovf_q) begin
            seg0_d = SEG_DASH;
            seg1_d = SEG_DASH;
            seg2_d = SEG_DASH;
            seg3_d = SEG_DASH;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg0_q  <= SEG_BLANK;
            seg1_q  <= SEG_BLANK;
            seg2_q  <= SEG_BLANK;
            seg3_q  <= SEG_BLANK;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Load) begin
                        bin_q   <= Value;
                        bcd_q   <= 16'd0;
                        cnt_q   <= 4'd0;
                        ovf_q   <= (Value > 14'd9999);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= shift_d[29:14];
                    bin_q <= shift_d[13:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd13) begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    // All four digits commit on one edge so the display never sees a mix.
                    seg0_q  <= seg0_d;
                    seg1_q  <= seg1_d;
                    seg2_q  <= seg2_d;
                    seg3_q  <= seg3_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign seg0 = seg0_q;
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign seg3 = seg3_q;

endmodule

// File: tb/tb_bcd_seg_encoder.sv
// Bench for bcd_seg_encoder: directed scenarios plus random values checked against
// a decimal-arithmetic reference model, with blanking both enabled and disabled.
module tb_bcd_seg_encoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [13:0] Value;
    logic        Load;
    logic        Busy, Done;
    logic [7:0]  seg0, seg1, seg2, seg3;
    logic        Busy_nb, Done_nb;
    logic [7:0]  seg0_nb, seg1_nb, seg2_nb, seg3_nb;

    int nvec = 0;
    int nerr = 0;

    always #5 Clk = ~Clk;

    bcd_seg_encoder dut (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load),
        .Busy(Busy), .Done(Done),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
    );

    bcd_seg_encoder #(.BLANK_LEADING(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load),
        .Busy(Busy_nb), .Done(Done_nb),
        .seg0(seg0_nb), .seg1(seg1_nb), .seg2(seg2_nb), .seg3(seg3_nb)
    );

    function automatic logic [7:0] dig(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int v, input bit blank);
        logic [7:0] w0, w1, w2, w3;
        if (v > 9999) return {4{8'hBF}};
        w0 = (blank && v < 1000) ? 8'hFF : dig(v / 1000);
        w1 = (blank && v < 100)  ? 8'hFF : dig((v / 100) % 10);
        w2 = (blank && v < 10)   ? 8'hFF : dig((v / 10) % 10);
        w3 = dig(v % 10);
        return {w0, w1, w2, w3};
    endfunction

    // Pulse Load with v, then observe 20 cycles; optionally inject a second Load at index extra_at.
    task automatic run_conv(input int v, input int extra_at, input int extra_v,
                            output int lat, output int busy_cnt, output int done_cnt,
                            output logic [31:0] w, output logic [31:0] w_nb);
        @(negedge Clk);
        Value = v[13:0];
        Load  = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        lat = -1; busy_cnt = 0; done_cnt = 0; w = '1; w_nb = '1;
        for (int i = 0; i < 20; i++) begin
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat  = i;
                    w    = {seg0, seg1, seg2, seg3};
                    w_nb = {seg0_nb, seg1_nb, seg2_nb, seg3_nb};
                end
            end
            if (i == extra_at) begin
                Value = extra_v[13:0];
                Load  = 1'b1;
            end else begin
                Load = 1'b0;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Load = 1'b0; Value = '0;
        repeat (2) @(negedge Clk);
        nvec++;
        if ({seg0, seg1, seg2, seg3} !== 32'hFFFFFFFF) begin
            nerr++; $display("FAIL reset_segs: got %h expected ffffffff", {seg0, seg1, seg2, seg3});
        end
        nvec++;
        if (Busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        nvec++;
        if (Done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", Done); end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        logic [31:0] w, wn;
        run_conv(1234, -1, 0, lat, bc, dc, w, wn);
        nvec++;
        if (lat !== 15) begin nerr++; $display("FAIL basic_latency: got %0d expected 15", lat); end
        nvec++;
        if (bc !== 15) begin nerr++; $display("FAIL basic_busy_cycles: got %0d expected 15", bc); end
        nvec++;
        if (dc !== 1) begin nerr++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
        nvec++;
        if (w !== 32'hF9A4B099) begin nerr++; $display("FAIL basic_word: got %h expected f9a4b099", w); end
        nvec++;
        if (wn !== 32'hF9A4B099) begin nerr++; $display("FAIL basic_word_nb: got %h expected f9a4b099", wn); end
        repeat (3) @(negedge Clk);
        nvec++;
        if ({seg0, seg1, seg2, seg3} !== 32'hF9A4B099) begin
            nerr++; $display("FAIL basic_hold: got %h expected f9a4b099", {seg0, seg1, seg2, seg3});
        end
    endtask

    task automatic test_leading_zeros();
        int vals [3] = '{7, 0, 405};
        logic [31:0] exps [3] = '{32'hFFFFFFF8, 32'hFFFFFFC0, 32'hFF99C092};
        int lat, bc, dc;
        logic [31:0] w, wn;
        for (int k = 0; k < 3; k++) begin
            run_conv(vals[k], -1, 0, lat, bc, dc, w, wn);
            nvec++;
            if (w !== exps[k]) begin
                nerr++; $display("FAIL blank_%0d: got %h expected %h", vals[k], w, exps[k]);
            end
            if (k == 0) begin
                nvec++;
                if (wn !== 32'hC0C0C0F8) begin
                    nerr++; $display("FAIL noblank_7: got %h expected c0c0c0f8", wn);
                end
            end
        end
    endtask

    task automatic test_bounds();
        int vals [3] = '{9999, 10000, 16383};
        logic [31:0] exps [3] = '{32'h90909090, 32'hBFBFBFBF, 32'hBFBFBFBF};
        int lat, bc, dc;
        logic [31:0] w, wn;
        for (int k = 0; k < 3; k++) begin
            run_conv(vals[k], -1, 0, lat, bc, dc, w, wn);
            nvec++;
            if (w !== exps[k]) begin
                nerr++; $display("FAIL bound_%0d: got %h expected %h", vals[k], w, exps[k]);
            end
            nvec++;
            if (wn !== exps[k]) begin
                nerr++; $display("FAIL bound_nb_%0d: got %h expected %h", vals[k], wn, exps[k]);
            end
        end
    endtask

    task automatic test_load_ignored();
        int lat, bc, dc;
        logic [31:0] w, wn;
        run_conv(1234, 5, 5678, lat, bc, dc, w, wn);
        nvec++;
        if (w !== 32'hF9A4B099) begin nerr++; $display("FAIL ignore_word: got %h expected f9a4b099", w); end
        nvec++;
        if (dc !== 1) begin nerr++; $display("FAIL ignore_done_pulses: got %0d expected 1", dc); end
        nvec++;
        if (lat !== 15) begin nerr++; $display("FAIL ignore_latency: got %0d expected 15", lat); end
    endtask

    task automatic test_reset_mid();
        int dc = 0;
        int lat, bc, dc2;
        logic [31:0] w, wn;
        @(negedge Clk);
        Value = 14'd9999;
        Load  = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) dc++;
            if (i == 9) begin
                nvec++;
                if ({seg0, seg1, seg2, seg3} !== 32'hFFFFFFFF) begin
                    nerr++; $display("FAIL midreset_segs: got %h expected ffffffff", {seg0, seg1, seg2, seg3});
                end
                nvec++;
                if (Busy !== 1'b0) begin nerr++; $display("FAIL midreset_busy: got %b expected 0", Busy); end
            end
            Reset = (i == 8);
            @(negedge Clk);
        end
        nvec++;
        if (dc !== 0) begin nerr++; $display("FAIL midreset_no_done: got %0d expected 0", dc); end
        run_conv(42, -1, 0, lat, bc, dc2, w, wn);
        nvec++;
        if (w !== 32'hFFFF99A4) begin nerr++; $display("FAIL after_reset_42: got %h expected ffff99a4", w); end
        nvec++;
        if (lat !== 15) begin nerr++; $display("FAIL after_reset_latency: got %0d expected 15", lat); end
    endtask

    task automatic test_back_to_back();
        int done_idx [$];
        logic [31:0] words [$];
        @(negedge Clk);
        Value = 14'd321;
        Load  = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 40; i++) begin
            if (Done) begin
                done_idx.push_back(i);
                words.push_back({seg0, seg1, seg2, seg3});
            end
            if (i == 1) Value = 14'd8765;
            if (i == 16) begin
                nvec++;
                if (Busy !== 1'b1) begin nerr++; $display("FAIL b2b_reaccept_busy: got %b expected 1", Busy); end
                Load = 1'b0;
            end
            @(negedge Clk);
        end
        nvec++;
        if (done_idx.size() !== 2) begin
            nerr++; $display("FAIL b2b_done_count: got %0d expected 2", done_idx.size());
        end else begin
            nvec++;
            if (done_idx[0] !== 15 || done_idx[1] !== 31) begin
                nerr++; $display("FAIL b2b_done_times: got %0d,%0d expected 15,31", done_idx[0], done_idx[1]);
            end
            nvec++;
            if (words[0] !== ref_word(321, 1'b1)) begin
                nerr++; $display("FAIL b2b_first: got %h expected %h", words[0], ref_word(321, 1'b1));
            end
            nvec++;
            if (words[1] !== ref_word(8765, 1'b1)) begin
                nerr++; $display("FAIL b2b_second: got %h expected %h", words[1], ref_word(8765, 1'b1));
            end
        end
    endtask

    task automatic test_random();
        int v, lat, bc, dc;
        logic [31:0] w, wn;
        for (int k = 0; k < 40; k++) begin
            v = int'($urandom_range(0, 16383));
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 120));
            run_conv(v, -1, 0, lat, bc, dc, w, wn);
            nvec++;
            if (lat !== 15) begin nerr++; $display("FAIL rand_latency v=%0d: got %0d expected 15", v, lat); end
            nvec++;
            if (w !== ref_word(v, 1'b1)) begin
                nerr++; $display("FAIL rand_word v=%0d: got %h expected %h", v, w, ref_word(v, 1'b1));
            end
            nvec++;
            if (wn !== ref_word(v, 1'b0)) begin
                nerr++; $display("FAIL rand_word_nb v=%0d: got %h expected %h", v, wn, ref_word(v, 1'b0));
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Load  = 1'b0;
        Value = '0;
        test_reset();
        test_basic();
        test_leading_zeros();
        test_bounds();
        test_load_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
